// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - forwarding source / instruction kind encodings and stage rules
package fwd_hazard_ctrl_pkg;

  localparam logic [2:0] FWD_SRC_GR      = 3'd0;
  localparam logic [2:0] FWD_SRC_EX      = 3'd1;
  localparam logic [2:0] FWD_SRC_MM1     = 3'd2;
  localparam logic [2:0] FWD_SRC_MM2_REG = 3'd3;
  localparam logic [2:0] FWD_SRC_MM2_MEM = 3'd4;
  localparam logic [2:0] FWD_SRC_WB      = 3'd5;

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_MUL  = 2'd1;
  localparam logic [1:0] KIND_LOAD = 2'd2;

  // Shadow stage slots, youngest first
  localparam logic [1:0] STG_EX  = 2'd0;
  localparam logic [1:0] STG_MM1 = 2'd1;
  localparam logic [1:0] STG_MM2 = 2'd2;
  localparam logic [1:0] STG_WB  = 2'd3;
  localparam int         N_STG   = 4;

  // Only ALU results exist before MM2; MUL and LOAD results appear in MM2.
  function automatic logic stage_ready(input logic [1:0] stg, input logic [1:0] kind);
    return (kind == KIND_ALU) || (stg == STG_MM2) || (stg == STG_WB);
  endfunction

  function automatic logic [2:0] stage_src(input logic [1:0] stg, input logic [1:0] kind);
    logic [2:0] src;
    case (stg)
      STG_EX:  src = FWD_SRC_EX;
      STG_MM1: src = FWD_SRC_MM1;
      STG_MM2: src = (kind == KIND_LOAD) ? FWD_SRC_MM2_MEM : FWD_SRC_MM2_REG;
      default: src = FWD_SRC_WB;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/fwd_sel_lookup.sv
// rtl/fwd_sel_lookup.sv - per-operand forwarding source select and stall detect
module fwd_sel_lookup
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NREG_W = 5
) (
  input  logic [NREG_W-1:0]            idx,
  input  logic                         rd_en,
  input  logic [N_STG-1:0]             ent_valid,
  input  logic [N_STG-1:0]             ent_we,
  input  logic [N_STG-1:0][NREG_W-1:0] ent_dest,
  input  logic [N_STG-1:0][1:0]        ent_kind,
  output logic [2:0]                   fwd_ctrl,
  output logic                         stall
);

  logic hit;

  // The first (youngest) matching producer decides; older entries are ignored
  // even when the youngest one cannot forward yet.
  always_comb begin
    fwd_ctrl = FWD_SRC_GR;
    stall    = 1'b0;
    hit      = 1'b0;
    if (rd_en && (idx != '0)) begin
      for (int s = 0; s < N_STG; s++) begin
        if (!hit && ent_valid[s] && ent_we[s] && (ent_dest[s] == idx)) begin
          hit = 1'b1;
          if (stage_ready(2'(s), ent_kind[s])) begin
            fwd_ctrl = stage_src(2'(s), ent_kind[s]);
          end else begin
            stall = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX/MM1/MM2/WB destination scoreboard driving ID forwarding selects
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NREG_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [NREG_W-1:0] id_rj,
  input  logic              id_rj_rd,
  input  logic [NREG_W-1:0] id_rk,
  input  logic              id_rk_rd,
  input  logic [NREG_W-1:0] id_dest,
  input  logic              id_we,
  input  logic [1:0]        id_kind,
  input  logic              pipe_hold,
  input  logic              id_flush,
  output logic [2:0]        fwd_ctrl_a,
  output logic [2:0]        fwd_ctrl_b,
  output logic              id_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [N_STG-1:0]             ent_valid_q, ent_valid_d;
  logic [N_STG-1:0]             ent_we_q,    ent_we_d;
  logic [N_STG-1:0][NREG_W-1:0] ent_dest_q,  ent_dest_d;
  logic [N_STG-1:0][1:0]        ent_kind_q,  ent_kind_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic stall_a;
  logic stall_b;

  fwd_sel_lookup #(.NREG_W(NREG_W)) u_sel_a (
    .idx       (id_rj),
    .rd_en     (id_rj_rd),
    .ent_valid (ent_valid_q),
    .ent_we    (ent_we_q),
    .ent_dest  (ent_dest_q),
    .ent_kind  (ent_kind_q),
    .fwd_ctrl  (fwd_ctrl_a),
    .stall     (stall_a)
  );

  fwd_sel_lookup #(.NREG_W(NREG_W)) u_sel_b (
    .idx       (id_rk),
    .rd_en     (id_rk_rd),
    .ent_valid (ent_valid_q),
    .ent_we    (ent_we_q),
    .ent_dest  (ent_dest_q),
    .ent_kind  (ent_kind_q),
    .fwd_ctrl  (fwd_ctrl_b),
    .stall     (stall_b)
  );

  assign id_stall  = id_valid & (stall_a | stall_b);
  assign stall_cnt = stall_cnt_q;

  // A held pipeline freezes every slot, including an EX branch that flushes ID.
  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_we_d    = ent_we_q;
    ent_dest_d  = ent_dest_q;
    ent_kind_d  = ent_kind_q;
    stall_cnt_d = stall_cnt_q;
    if (!pipe_hold) begin
      for (int s = 1; s < N_STG; s++) begin
        ent_valid_d[s] = ent_valid_q[s-1];
        ent_we_d[s]    = ent_we_q[s-1];
        ent_dest_d[s]  = ent_dest_q[s-1];
        ent_kind_d[s]  = ent_kind_q[s-1];
      end
      if (id_valid && !id_stall && !id_flush) begin
        ent_valid_d[STG_EX] = 1'b1;
        ent_we_d[STG_EX]    = id_we;
        ent_dest_d[STG_EX]  = id_dest;
        ent_kind_d[STG_EX]  = id_kind;
      end else begin
        ent_valid_d[STG_EX] = 1'b0;
        ent_we_d[STG_EX]    = 1'b0;
        ent_dest_d[STG_EX]  = '0;
        ent_kind_d[STG_EX]  = KIND_ALU;
      end
      if (id_stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ent_valid_q <= '0;
      ent_we_q    <= '0;
      ent_dest_q  <= '0;
      ent_kind_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_we_q    <= ent_we_d;
      ent_dest_q  <= ent_dest_d;
      ent_kind_q  <= ent_kind_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed vectors plus randomized age-based model for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  localparam logic [2:0] GR = 3'd0, EX = 3'd1, MM1 = 3'd2, MREG = 3'd3, MMEM = 3'd4, WB = 3'd5;
  localparam logic [1:0] ALU = 2'd0, MUL = 2'd1, LD = 2'd2;

  logic        clk;
  logic        resetn;
  logic        id_valid;
  logic [4:0]  id_rj;
  logic        id_rj_rd;
  logic [4:0]  id_rk;
  logic        id_rk_rd;
  logic [4:0]  id_dest;
  logic        id_we;
  logic [1:0]  id_kind;
  logic        pipe_hold;
  logic        id_flush;
  logic [2:0]  fwd_ctrl_a;
  logic [2:0]  fwd_ctrl_b;
  logic        id_stall;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl #(.NREG_W(5), .CNT_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .id_valid   (id_valid),
    .id_rj      (id_rj),
    .id_rj_rd   (id_rj_rd),
    .id_rk      (id_rk),
    .id_rk_rd   (id_rk_rd),
    .id_dest    (id_dest),
    .id_we      (id_we),
    .id_kind    (id_kind),
    .pipe_hold  (pipe_hold),
    .id_flush   (id_flush),
    .fwd_ctrl_a (fwd_ctrl_a),
    .fwd_ctrl_b (fwd_ctrl_b),
    .id_stall   (id_stall),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rj;
    logic       rjr;
    logic [4:0] rk;
    logic       rkr;
    logic [4:0] dst;
    logic       we;
    logic [1:0] kind;
    logic       hold;
    logic       flush;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       es;
    int         ec;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] rj, logic rjr, logic [4:0] rk, logic rkr,
                              logic [4:0] dst, logic we, logic [1:0] kind, logic hold, logic flush,
                              logic [2:0] ea, logic [2:0] eb, logic es, int ec);
    vec_t t;
    t.v = v; t.rj = rj; t.rjr = rjr; t.rk = rk; t.rkr = rkr; t.dst = dst; t.we = we;
    t.kind = kind; t.hold = hold; t.flush = flush; t.ea = ea; t.eb = eb; t.es = es; t.ec = ec;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    id_valid = t.v; id_rj = t.rj; id_rj_rd = t.rjr; id_rk = t.rk; id_rk_rd = t.rkr;
    id_dest = t.dst; id_we = t.we; id_kind = t.kind; pipe_hold = t.hold; id_flush = t.flush;
  endtask

  // Inputs are applied 1 time unit after a rising edge and checked 1 unit later.
  task automatic do_cycle(string tag, vec_t t);
    drive(t);
    #1;
    chk({tag, " fwd_a"}, int'(fwd_ctrl_a), int'(t.ea));
    chk({tag, " fwd_b"}, int'(fwd_ctrl_b), int'(t.eb));
    chk({tag, " stall"}, int'(id_stall), int'(t.es));
    if (t.ec >= 0) chk({tag, " cnt"}, int'(stall_cnt), t.ec);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, GR, GR, 0, 0));
  endtask

  // Model: m_*[a] is the instruction issued a cycles ago (a=1 is EX ... a=4 is WB).
  logic       m_v[1:4];
  logic       m_we[1:4];
  logic [4:0] m_dst[1:4];
  logic [1:0] m_kind[1:4];
  longint     m_cnt;

  task automatic model_reset();
    for (int a = 1; a <= 4; a++) begin
      m_v[a] = 0; m_we[a] = 0; m_dst[a] = 0; m_kind[a] = ALU;
    end
    m_cnt = 0;
  endtask

  task automatic model_op(input logic [4:0] idx, input logic rd, output logic [2:0] src, output logic st);
    int age;
    src = GR;
    st  = 0;
    age = 0;
    if (rd && idx != 0) begin
      for (int a = 1; a <= 4; a++)
        if (age == 0 && m_v[a] && m_we[a] && m_dst[a] == idx) age = a;
      if (age != 0) begin
        // ALU results exist after 1 cycle; MUL/LOAD results only after 3.
        if (m_kind[age] != ALU && age < 3) st = 1;
        else if (age == 1) src = EX;
        else if (age == 2) src = MM1;
        else if (age == 3) src = (m_kind[age] == LD) ? MMEM : MREG;
        else src = WB;
      end
    end
  endtask

  task automatic reset_dut();
    idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    model_reset();
  endtask

  vec_t tbl[17];
  vec_t seq[9];

  initial begin
    resetn = 0;
    idle();
    reset_dut();

    #1;
    chk("reset fwd_a", int'(fwd_ctrl_a), int'(GR));
    chk("reset fwd_b", int'(fwd_ctrl_b), int'(GR));
    chk("reset stall", int'(id_stall), 0);
    chk("reset cnt", int'(stall_cnt), 0);
    @(posedge clk);
    #1;

    //           v rj r rk r dst we kind  h f   ea    eb   es cnt
    tbl[0]  = mk(1, 0,0, 0,0, 4, 1, ALU, 0,0, GR,   GR,  0, 0);
    tbl[1]  = mk(1, 4,1, 0,1, 0, 0, ALU, 0,0, EX,   GR,  0, 0);
    tbl[2]  = mk(1, 4,0, 0,0, 5, 1, LD,  0,0, GR,   GR,  0, 0);
    tbl[3]  = mk(1, 5,1, 0,0, 7, 1, ALU, 0,0, GR,   GR,  1, 0);
    tbl[4]  = mk(1, 5,1, 0,0, 7, 1, ALU, 0,0, GR,   GR,  1, 1);
    tbl[5]  = mk(1, 5,1, 0,0, 7, 1, ALU, 0,0, MMEM, GR,  0, 2);
    tbl[6]  = mk(1, 0,0, 0,0, 6, 1, ALU, 0,0, GR,   GR,  0, 2);
    tbl[7]  = mk(1, 0,0, 0,0, 0, 0, ALU, 0,0, GR,   GR,  0, 2);
    tbl[8]  = mk(1, 0,0, 0,0, 0, 0, ALU, 0,0, GR,   GR,  0, 2);
    tbl[9]  = mk(1, 0,0, 0,0, 6, 1, ALU, 0,0, GR,   GR,  0, 2);
    tbl[10] = mk(1, 6,1, 6,1, 6, 1, ALU, 0,0, EX,   EX,  0, 2);
    tbl[11] = mk(1, 0,0, 0,0, 0, 0, ALU, 0,0, GR,   GR,  0, 2);
    tbl[12] = mk(1, 0,0, 0,0, 6, 1, LD,  0,0, GR,   GR,  0, 2);
    tbl[13] = mk(1, 6,1, 6,1, 0, 0, ALU, 0,0, GR,   GR,  1, 2);
    tbl[14] = mk(0, 6,1, 0,0, 0, 0, ALU, 0,0, GR,   GR,  0, 3);
    tbl[15] = mk(1, 6,1, 0,0, 0, 1, ALU, 0,0, MMEM, GR,  0, 3);
    tbl[16] = mk(1, 0,1, 6,1, 0, 0, ALU, 0,0, GR,   WB,  0, 3);
    for (int i = 0; i < 17; i++) do_cycle($sformatf("tbl%0d", i), tbl[i]);

    // Load in MM1 held for 3 cycles, then a flushed producer, then a reset pulse.
    reset_dut();
    seq[0] = mk(1, 0,0, 0,0, 5, 1, LD,  0,0, GR,   GR,  0, 0);
    seq[1] = mk(1, 5,1, 0,0, 8, 1, ALU, 0,0, GR,   GR,  1, 0);
    seq[2] = mk(1, 5,1, 0,0, 8, 1, ALU, 1,0, GR,   GR,  1, 1);
    seq[3] = mk(1, 5,1, 0,0, 8, 1, ALU, 1,0, GR,   GR,  1, 1);
    seq[4] = mk(1, 5,1, 0,0, 8, 1, ALU, 1,0, GR,   GR,  1, 1);
    seq[5] = mk(1, 5,1, 0,0, 8, 1, ALU, 0,0, GR,   GR,  1, 1);
    seq[6] = mk(1, 5,1, 0,0, 8, 1, ALU, 0,1, MMEM, GR,  0, 2);
    seq[7] = mk(1, 8,1, 0,0, 9, 1, ALU, 0,0, GR,   GR,  0, 2);
    seq[8] = mk(1, 9,1, 9,1, 0, 0, ALU, 0,0, GR,   GR,  0, 0);
    for (int i = 0; i < 8; i++) do_cycle($sformatf("seq%0d", i), seq[i]);
    resetn = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    do_cycle("seq8", seq[8]);

    // Randomized run against the age-based model.
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] ea, eb;
      logic       sa, sb, es;
      id_valid  = ($urandom_range(0, 9) < 8);
      id_rj     = 5'($urandom_range(0, 7));
      id_rj_rd  = 1'($urandom_range(0, 1));
      id_rk     = 5'($urandom_range(0, 7));
      id_rk_rd  = 1'($urandom_range(0, 1));
      id_dest   = 5'($urandom_range(0, 7));
      id_we     = ($urandom_range(0, 3) != 0);
      id_kind   = 2'($urandom_range(0, 2));
      pipe_hold = ($urandom_range(0, 9) == 0);
      id_flush  = ($urandom_range(0, 9) == 0);
      model_op(id_rj, id_rj_rd, ea, sa);
      model_op(id_rk, id_rk_rd, eb, sb);
      es = id_valid & (sa | sb);
      #1;
      chk($sformatf("rnd%0d fwd_a", n), int'(fwd_ctrl_a), int'(ea));
      chk($sformatf("rnd%0d fwd_b", n), int'(fwd_ctrl_b), int'(eb));
      chk($sformatf("rnd%0d stall", n), int'(id_stall), int'(es));
      chk($sformatf("rnd%0d cnt", n), int'(stall_cnt), int'(m_cnt));
      if (!pipe_hold) begin
        for (int a = 4; a >= 2; a--) begin
          m_v[a] = m_v[a-1]; m_we[a] = m_we[a-1]; m_dst[a] = m_dst[a-1]; m_kind[a] = m_kind[a-1];
        end
        m_v[1] = id_valid & ~es & ~id_flush;
        m_we[1] = id_we; m_dst[1] = id_dest; m_kind[1] = id_kind;
        if (es && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
